// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with a frame-synchronous shadow load,
// per-digit blinking, decimal points and selectable output polarity.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic                    load_i,
   input  logic [5*NUM_DIGITS-1:0] codes_in_i,
   input  logic [NUM_DIGITS-1:0]   dp_in_i,
   input  logic [NUM_DIGITS-1:0]   blink_mask_i,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic                    pending_o,
   output logic                    frame_tick_o
);

   localparam int unsigned PrescW = $clog2(SCAN_DIV);
   localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
   localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PrescW-1:0] PrescLast = PrescW'(SCAN_DIV - 1);
   localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);
   localparam logic [4:0]        CodeBlank = 5'h10;

   logic [PrescW-1:0]       presc_q, presc_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [BlinkW-1:0]       bcnt_q, bcnt_d;
   logic                    phase_q, phase_d;
   logic [5*NUM_DIGITS-1:0] act_code_q, act_code_d, sh_code_q, sh_code_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
   logic                    pending_q, pending_d;
   logic                    frame_tick_q;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;

   logic                    slot_tick, frame;
   logic [4:0]              cur_code;
   logic [6:0]              rom_seg;
   logic [NUM_DIGITS-1:0]   an_lit;
   logic [6:0]              seg_lit;
   logic                    dp_lit;

   assign slot_tick = (presc_q == PrescLast);
   assign frame     = slot_tick && (idx_q == IdxLast);
   assign cur_code  = act_code_q[5*idx_q +: 5];

   always_comb begin
      unique case (cur_code)
         5'h00:   rom_seg = 7'b1111110;
         5'h01:   rom_seg = 7'b0110000;
         5'h02:   rom_seg = 7'b1101101;
         5'h03:   rom_seg = 7'b1111001;
         5'h04:   rom_seg = 7'b0110011;
         5'h05:   rom_seg = 7'b1011011;
         5'h06:   rom_seg = 7'b1011111;
         5'h07:   rom_seg = 7'b1110000;
         5'h08:   rom_seg = 7'b1111111;
         5'h09:   rom_seg = 7'b1111011;
         5'h0A:   rom_seg = 7'b1110111;
         5'h0B:   rom_seg = 7'b0011111;
         5'h0C:   rom_seg = 7'b1001110;
         5'h0D:   rom_seg = 7'b0111101;
         5'h0E:   rom_seg = 7'b1001111;
         5'h0F:   rom_seg = 7'b1000111;
         5'h11:   rom_seg = 7'b0001110;
         5'h12:   rom_seg = 7'b0000001;
         5'h13:   rom_seg = 7'b1100111;
         5'h14:   rom_seg = 7'b0000101;
         5'h15:   rom_seg = 7'b0010101;
         5'h16:   rom_seg = 7'b0011101;
         default: rom_seg = 7'b0000000;
      endcase
   end

   always_comb begin
      an_lit  = '0;
      seg_lit = '0;
      dp_lit  = 1'b0;
      if (en_i) begin
         an_lit[idx_q] = 1'b1;
         // A blinking digit stays selected but shows nothing in the off phase.
         if (!(blink_mask_i[idx_q] && phase_q)) begin
            seg_lit = rom_seg;
            dp_lit  = act_dp_q[idx_q];
         end
      end
      an_d  = ACTIVE_LOW ? ~an_lit : an_lit;
      seg_d = ACTIVE_LOW ? ~seg_lit : seg_lit;
      dp_d  = ACTIVE_LOW ? ~dp_lit : dp_lit;
   end

   always_comb begin
      presc_d    = slot_tick ? '0 : presc_q + 1'b1;
      idx_d      = idx_q;
      bcnt_d     = bcnt_q;
      phase_d    = phase_q;
      act_code_d = act_code_q;
      act_dp_d   = act_dp_q;
      sh_code_d  = sh_code_q;
      sh_dp_d    = sh_dp_q;
      pending_d  = pending_q;
      if (slot_tick) begin
         idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
      if (frame) begin
         if (bcnt_q == BlinkLast) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
         if (pending_q) begin
            act_code_d = sh_code_q;
            act_dp_d   = sh_dp_q;
            pending_d  = 1'b0;
         end
      end
      // A load always lands in the shadow; on a boundary it waits one more frame.
      if (load_i) begin
         sh_code_d = codes_in_i;
         sh_dp_d   = dp_in_i;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q      <= '0;
         idx_q        <= '0;
         bcnt_q       <= '0;
         phase_q      <= 1'b0;
         act_code_q   <= {NUM_DIGITS{CodeBlank}};
         sh_code_q    <= {NUM_DIGITS{CodeBlank}};
         act_dp_q     <= '0;
         sh_dp_q      <= '0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         an_q         <= {NUM_DIGITS{ACTIVE_LOW}};
         seg_q        <= {7{ACTIVE_LOW}};
         dp_q         <= ACTIVE_LOW;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         bcnt_q       <= bcnt_d;
         phase_q      <= phase_d;
         act_code_q   <= act_code_d;
         sh_code_q    <= sh_code_d;
         act_dp_q     <= act_dp_d;
         sh_dp_q      <= sh_dp_d;
         pending_q    <= pending_d;
         frame_tick_q <= frame;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign an_o         = an_q;
   assign seg_o        = seg_q;
   assign dp_o         = dp_q;
   assign pending_o    = pending_q;
   assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver against a cycle-count based reference model.
module tb_seg7_scan_driver;

   localparam int unsigned N  = 4;
   localparam int unsigned SD = 4;
   localparam int unsigned BF = 2;
   localparam bit          AL = 1'b1;
   localparam int unsigned FR = SD * N;

   localparam logic [6:0] ROM [0:22] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
      7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111, 7'b0000000, 7'b0001110,
      7'b0000001, 7'b1100111, 7'b0000101, 7'b0010101, 7'b0011101};

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b1;
   logic           load = 1'b0;
   logic [5*N-1:0] codes = '0;
   logic [N-1:0]   dpi = '0;
   logic [N-1:0]   mask = '0;
   logic [N-1:0]   an;
   logic [6:0]     seg;
   logic           dp, pending, frame_tick;

   seg7_scan_driver #(
      .NUM_DIGITS  (N),
      .SCAN_DIV    (SD),
      .BLINK_FRAMES(BF),
      .ACTIVE_LOW  (AL)
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .load_i      (load),
      .codes_in_i  (codes),
      .dp_in_i     (dpi),
      .blink_mask_i(mask),
      .an_o        (an),
      .seg_o       (seg),
      .dp_o        (dp),
      .pending_o   (pending),
      .frame_tick_o(frame_tick)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model: position in the scan derives purely from cycles since reset.
   int          k = 0;
   logic [4:0]  m_act [N];
   logic [4:0]  m_sh  [N];
   logic [N-1:0] m_act_dp, m_sh_dp;
   logic        m_pend;
   logic [N-1:0] e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_pend, e_ft;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
      end
   endtask

   function automatic logic [6:0] rom_of(input logic [4:0] c);
      logic [6:0] r;
      r = (c < 5'd23) ? ROM[c] : 7'b0000000;
      return r;
   endfunction

   task automatic model_edge();
      int          idx, phase;
      bit          boundary;
      logic [N-1:0] lan;
      logic [6:0]  lseg;
      logic        ldp;
      if (rst) begin
         k = 0;
         for (int d = 0; d < N; d++) begin
            m_act[d] = 5'h10;
            m_sh[d]  = 5'h10;
         end
         m_act_dp = '0;
         m_sh_dp  = '0;
         m_pend   = 1'b0;
         e_an     = {N{AL}};
         e_seg    = {7{AL}};
         e_dp     = AL;
         e_pend   = 1'b0;
         e_ft     = 1'b0;
         return;
      end
      idx   = (k / SD) % N;
      phase = ((k / FR) / BF) % 2;
      lan   = '0;
      lseg  = '0;
      ldp   = 1'b0;
      if (en) begin
         lan = N'(1) << idx;
         if (!(mask[idx] && phase == 1)) begin
            lseg = rom_of(m_act[idx]);
            ldp  = m_act_dp[idx];
         end
      end
      e_an  = AL ? ~lan : lan;
      e_seg = AL ? ~lseg : lseg;
      e_dp  = AL ? ~ldp : ldp;
      boundary = ((k % FR) == FR - 1);
      e_ft = boundary;
      if (boundary && m_pend) begin
         m_act    = m_sh;
         m_act_dp = m_sh_dp;
      end
      if (load) begin
         for (int d = 0; d < N; d++) m_sh[d] = codes[5*d +: 5];
         m_sh_dp = dpi;
         m_pend  = 1'b1;
      end else if (boundary) begin
         m_pend = 1'b0;
      end
      e_pend = m_pend;
      k++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("pending", 32'(pending), 32'(e_pend));
      check("frame_tick", 32'(frame_tick), 32'(e_ft));
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic do_load(input logic [5*N-1:0] c, input logic [N-1:0] d);
      codes = c;
      dpi   = d;
      load  = 1'b1;
      step();
      load  = 1'b0;
   endtask

   // Advance until the next edge is a frame boundary (at most one frame).
   task automatic to_boundary();
      for (int i = 0; i < FR && (k % FR) != FR - 1; i++) step();
   endtask

   initial begin
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      run(37);
      do_load({5'h11, 5'h0E, 5'h0A, 5'h10}, 4'b0000);
      run(40);
      do_load({4{5'h01}}, 4'b0000);
      run(3);
      do_load({4{5'h02}}, 4'b0010);
      run(40);
      to_boundary();
      do_load({5'h13, 5'h14, 5'h15, 5'h16}, 4'b1000);
      run(40);
      mask = 4'b0001;
      do_load({4{5'h08}}, 4'b0001);
      run(150);
      run(5);
      en = 1'b0;
      run(7);
      en = 1'b1;
      run(20);
      // Reset with a load in the same cycle must leave nothing pending.
      codes = {4{5'h03}};
      load  = 1'b1;
      rst   = 1'b1;
      step();
      load  = 1'b0;
      step();
      rst   = 1'b0;
      run(20);
      for (int i = 0; i < 3000; i++) begin
         load  = ($urandom_range(0, 11) == 0);
         codes = (5*N)'($urandom);
         dpi   = N'($urandom);
         if ($urandom_range(0, 39) == 0) mask = N'($urandom);
         if ($urandom_range(0, 29) == 0) en = ~en;
         rst   = ($urandom_range(0, 499) == 0);
         step();
      end
      rst  = 1'b0;
      load = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed multi-digit seven-segment driver for the stopwatch display path.
- Holds one 5-bit character code per digit and scans the digits in turn. Characters are hex 0-F plus a letter/symbol set.
- Adds tear-free frame-synchronous loading, per-digit blinking, decimal points and selectable output polarity.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- SCAN_DIV, 100000: clk cycles per digit slot (>=2).
- BLINK_FRAMES, 64: full frames per blink half-period (>=1).
- ACTIVE_LOW, 1: 1 = an/seg/dp driven active-low (common-anode board); 0 = active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = scan and display; 0 = all digits dark (scan keeps running)
- load  in  1  one-cycle strobe: capture codes_in/dp_in into shadow
- codes_in  in  5*NUM_DIGITS  digit i code at [5i+4:5i]; digit 0 = rightmost
- dp_in  in  NUM_DIGITS  decimal point per digit
- blink_mask  in  NUM_DIGITS  live (unshadowed) per-digit blink enable
- an  out  NUM_DIGITS  digit enables, one-hot when lit
- seg  out  7  segments {a,b,c,d,e,f,g}, MSB = a
- dp  out  1  decimal point
- pending  out  1  shadow loaded, not yet applied
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (clk edge with rst=1):
  - prescaler=0, digit index=0, blink phase=0, blink frame count=0.
  - pending=0, frame_tick=0.
  - Active and shadow codes = 0x10 (blank); active and shadow dp = 0.
  - an/seg/dp at inactive level (all 1 if ACTIVE_LOW, else all 0).
  - Reset mid-load discards the shadow.
- Prescaler counts 0..SCAN_DIV-1 and wraps. A slot tick occurs on the cycle the prescaler equals SCAN_DIV-1.
- On a slot tick the index advances; NUM_DIGITS-1 wraps to 0.
- Frame boundary = slot tick while index==NUM_DIGITS-1. On a frame boundary:
  - frame_tick pulses high for the next cycle only.
  - If pending=1: shadow copies into active and pending clears, both on that edge.
- load=1: shadow <= codes_in/dp_in and pending <= 1 on the same edge.
  - A load while pending overwrites the shadow; only one apply occurs.
  - If load coincides with a frame boundary, the new data goes to the shadow, pending stays 1, and it applies at the next boundary. Active never takes the same-cycle inputs directly.
- Blink:
  - The frame counter increments per boundary.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - Digit i is forced blank (segments and dp off) when blink_mask[i]=1 and phase=1.
- Character ROM (abcdefg):
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, b:0011111, C:1001110, d:0111101, E:1001111, F:1000111
  - 0x10 blank:0000000, 0x11 L:0001110, 0x12 '-':0000001, 0x13 P:1100111, 0x14 r:0000101, 0x15 n:0010101, 0x16 o:0011101
  - 0x17..0x1F blank.
- Outputs are registered: one-cycle latency from index/active/blink/en to an/seg/dp.
  - an has exactly bit[index] asserted when en=1.
  - en=0 gives all inactive on the next cycle.
  - ACTIVE_LOW inverts an, seg and dp uniformly.

Test Plan:
- Reset/scan (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1, en=1):
  - rst high 2 cycles -> an=4'b1111, seg=7'b1111111, pending=0.
  - After release -> an cycles 1110,1101,1011,0111, each 4 cycles; frame_tick every 16 cycles.
- Frame-sync load: load with codes {0x11,0x0E,0x0A,0x10} mid-frame -> pending=1, display unchanged until boundary. Next frame then shows:
  - digit3 seg=~0001110
  - digit2 seg=~1001111
  - digit1 seg=~1110111
  - digit0 blank
  - pending=0.
- Double load: load 0x01s, then 0x02s before the boundary -> only 2s appear at the boundary, no frame shows 1s.
- Load coincident with frame boundary -> pending stays 1; data appears one frame later.
- Blink (BLINK_FRAMES=2, blink_mask=4'b0001, all codes 8, dp_in=4'b0001):
  - digit0 alternates seg=~1111111/dp=0 and all-off every 2 frames.
  - other digits constant.
- en=0 mid-scan -> an=4'b1111 one cycle later; index continues; re-enable resumes at the current index.
